// File: rtl/gray_sync_pkg.sv
// ============================================================================
// Module : gray_sync_pkg
// Brief  : Gray/binary conversion helpers and synchroniser depth limits.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package gray_sync_pkg;

   localparam int STAGES_MIN = 2;
   localparam int STAGES_MAX = 4;

   // Converts a Gray code whose MSB index is msb; bits above msb return 0.
   function automatic logic [31:0] gray2bin(input logic [31:0] g, input int msb);
      logic [31:0] b;
      b = '0;
      for (int i = 31; i >= 0; i--) begin
         if (i == msb)
            b[i] = g[i];
         else if (i < msb)
            b[i] = g[i] ^ b[i+1];
      end
      return b;
   endfunction

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_stage_chain.sv
// ============================================================================
// Module : sync_stage_chain
// Brief  : Bare multi-flop synchroniser chain, async active-low reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_stage_chain
   import gray_sync_pkg::*;
#(
   parameter int Width  = 5,
   parameter int Stages = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [Width:0] i_d,
   output logic [Width:0] o_q
);

   if (Stages < STAGES_MIN || Stages > STAGES_MAX) begin : g_bad_stages
      $error("sync_stage_chain: Stages=%0d outside %0d..%0d", Stages, STAGES_MIN, STAGES_MAX);
   end

   (* ASYNC_REG = "TRUE" *) logic [Stages-1:0][Width:0] r_stage;

   for (genvar k = 0; k < Stages; k++) begin : g_stage
      if (k == 0) begin : g_first
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) r_stage[0] <= '0;
            else      r_stage[0] <= i_d;
         end
      end else begin : g_next
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) r_stage[k] <= '0;
            else      r_stage[k] <= r_stage[k-1];
         end
      end
   end

   assign o_q = r_stage[Stages-1];

endmodule

`default_nettype wire

// File: rtl/gray_ptr_sync.sv
// ============================================================================
// Module : gray_ptr_sync
// Brief  : Gray pointer CDC synchroniser with binary, advance and jump error.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gray_ptr_sync
   import gray_sync_pkg::*;
#(
   parameter int Width  = 5,
   parameter int Stages = 2,
   parameter int MaxAdv = 2**Width
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [Width:0] syn_in,
   input  logic           err_clr,
   output logic [Width:0] syn_out,
   output logic [Width:0] bin_out,
   output logic           changed,
   output logic [Width:0] advance,
   output logic           err
);

   logic [Width:0] w_sync;
   logic [Width:0] w_bin_next;
   logic [Width:0] w_adv;
   logic           w_err_set;

   logic [Width:0] r_bin;
   logic [Width:0] r_adv;
   logic           r_changed;
   logic           r_err;

   sync_stage_chain #(
      .Width  (Width),
      .Stages (Stages)
   ) u_chain (
      .clk (clk),
      .rst (rst),
      .i_d (syn_in),
      .o_q (w_sync)
   );

   // Advance wraps naturally at the pointer width, so 63 -> 0 reads as 1.
   assign w_bin_next = (Width+1)'(gray2bin(32'(w_sync), Width));
   assign w_adv      = w_bin_next - r_bin;
   assign w_err_set  = 32'(w_adv) > 32'(MaxAdv);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bin     <= '0;
         r_adv     <= '0;
         r_changed <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_bin     <= w_bin_next;
         r_adv     <= w_adv;
         r_changed <= (w_adv != '0);
         r_err     <= w_err_set | (r_err & ~err_clr);
      end
   end

   assign syn_out = w_sync;
   assign bin_out = r_bin;
   assign advance = r_adv;
   assign changed = r_changed;
   assign err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_gray_ptr_sync.sv
// ============================================================================
// Module : tb_gray_ptr_sync
// Brief  : Directed self-checking bench for gray_ptr_sync (Stages 2 and 3).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gray_ptr_sync;
   import gray_sync_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [5:0] syn_in = '0;
   logic       err_clr = 1'b0;
   logic [5:0] syn_out, bin_out, advance;
   logic       changed, err;

   logic       rst3 = 1'b0;
   logic [5:0] syn_in3 = '0;
   logic       err_clr3 = 1'b0;
   logic [5:0] syn_out3, bin_out3, advance3;
   logic       changed3, err3;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   gray_ptr_sync #(.Width(5), .Stages(2), .MaxAdv(32)) dut (
      .clk(clk), .rst(rst), .syn_in(syn_in), .err_clr(err_clr),
      .syn_out(syn_out), .bin_out(bin_out), .changed(changed),
      .advance(advance), .err(err)
   );

   gray_ptr_sync #(.Width(5), .Stages(3), .MaxAdv(32)) dut3 (
      .clk(clk), .rst(rst3), .syn_in(syn_in3), .err_clr(err_clr3),
      .syn_out(syn_out3), .bin_out(bin_out3), .changed(changed3),
      .advance(advance3), .err(err3)
   );

   function automatic logic [5:0] g6(input int n);
      return 6'(bin2gray(32'(n)));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [5:0] g);
      rst = 1'b0; syn_in = g; err_clr = 1'b0;
      tick(); tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; syn_in = 6'b000010;
      tick();
      n_checks++;
      if ({syn_out, bin_out, advance, changed, err} !== 20'd0) begin
         n_errors++;
         $display("FAIL reset_state: syn=%0d bin=%0d adv=%0d chg=%0b err=%0b, need all 0",
                  syn_out, bin_out, advance, changed, err);
      end
      rst = 1'b1;
      tick(); tick();
      n_checks++;
      if (syn_out !== 6'b000010 || bin_out !== 6'd0) begin
         n_errors++;
         $display("FAIL reset_edge2: syn=%b bin=%0d, need syn=000010 bin=0", syn_out, bin_out);
      end
      tick();
      n_checks++;
      if (bin_out !== 6'd3 || advance !== 6'd3 || changed !== 1'b1 || err !== 1'b0) begin
         n_errors++;
         $display("FAIL first_sample: bin=%0d adv=%0d chg=%0b err=%0b, need 3 3 1 0",
                  bin_out, advance, changed, err);
      end
      tick();
      n_checks++;
      if (changed !== 1'b0 || advance !== 6'd0 || bin_out !== 6'd3) begin
         n_errors++;
         $display("FAIL first_hold: bin=%0d adv=%0d chg=%0b, need 3 0 0", bin_out, advance, changed);
      end
   endtask

   task automatic test_steady_count();
      do_reset(g6(0));
      tick();
      for (int idx = 0; idx < 66; idx++) begin
         syn_in = g6(idx % 64);
         tick();
         if (idx >= 3) begin
            n_checks++;
            if (bin_out !== 6'((idx - 2) % 64) || advance !== 6'd1 || changed !== 1'b1 || err !== 1'b0) begin
               n_errors++;
               $display("FAIL count_%0d: bin=%0d adv=%0d chg=%0b err=%0b, need bin=%0d adv=1 chg=1 err=0",
                        idx, bin_out, advance, changed, err, (idx - 2) % 64);
            end
         end
      end
   endtask

   task automatic test_jump();
      syn_in = g6(10);
      repeat (4) tick();
      syn_in = g6(15);
      tick(); tick();
      n_checks++;
      if (changed !== 1'b0 || bin_out !== 6'd10) begin
         n_errors++;
         $display("FAIL jump_pre: bin=%0d chg=%0b, need bin=10 chg=0", bin_out, changed);
      end
      tick();
      n_checks++;
      if (bin_out !== 6'd15 || advance !== 6'd5 || changed !== 1'b1) begin
         n_errors++;
         $display("FAIL jump: bin=%0d adv=%0d chg=%0b, need 15 5 1", bin_out, advance, changed);
      end
      tick();
      n_checks++;
      if (bin_out !== 6'd15 || advance !== 6'd0 || changed !== 1'b0) begin
         n_errors++;
         $display("FAIL jump_hold: bin=%0d adv=%0d chg=%0b, need 15 0 0", bin_out, advance, changed);
      end
   endtask

   task automatic test_error();
      do_reset(g6(0));
      tick();
      syn_in = g6(40);
      tick(); tick(); tick();
      n_checks++;
      if (bin_out !== 6'd40 || advance !== 6'd40 || err !== 1'b1) begin
         n_errors++;
         $display("FAIL err_set: bin=%0d adv=%0d err=%0b, need 40 40 1", bin_out, advance, err);
      end
      tick(); tick();
      n_checks++;
      if (err !== 1'b1) begin
         n_errors++;
         $display("FAIL err_sticky: err=%0b, need 1", err);
      end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      n_checks++;
      if (err !== 1'b0) begin
         n_errors++;
         $display("FAIL err_clear: err=%0b, need 0", err);
      end
      // 40 -> 10 wraps to an advance of 34, above the 32 limit.
      syn_in = g6(10);
      tick(); tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      n_checks++;
      if (err !== 1'b1 || advance !== 6'd34 || bin_out !== 6'd10) begin
         n_errors++;
         $display("FAIL err_set_vs_clr: err=%0b adv=%0d bin=%0d, need 1 34 10", err, advance, bin_out);
      end
   endtask

   task automatic test_async_reset();
      do_reset(g6(0));
      tick();
      for (int n = 0; n <= 20; n++) begin
         syn_in = g6(n);
         tick();
      end
      #3;
      rst = 1'b0;
      #1;
      n_checks++;
      if ({syn_out, bin_out, advance, changed, err} !== 20'd0) begin
         n_errors++;
         $display("FAIL async_reset: syn=%0d bin=%0d adv=%0d chg=%0b err=%0b, need all 0",
                  syn_out, bin_out, advance, changed, err);
      end
      tick();
      rst = 1'b1;
      tick(); tick();
      n_checks++;
      if (syn_out !== g6(20) || bin_out !== 6'd0) begin
         n_errors++;
         $display("FAIL recover_sync: syn=%b bin=%0d, need syn=%b bin=0", syn_out, bin_out, g6(20));
      end
      tick();
      n_checks++;
      if (bin_out !== 6'd20 || advance !== 6'd20 || changed !== 1'b1 || err !== 1'b0) begin
         n_errors++;
         $display("FAIL recover_first: bin=%0d adv=%0d chg=%0b err=%0b, need 20 20 1 0",
                  bin_out, advance, changed, err);
      end
   endtask

   task automatic test_stages3();
      rst3 = 1'b0; syn_in3 = '0;
      tick();
      rst3 = 1'b1;
      syn_in3 = g6(7);
      tick(); tick();
      n_checks++;
      if (syn_out3 !== 6'd0) begin
         n_errors++;
         $display("FAIL s3_edge2: syn=%b, need 000000", syn_out3);
      end
      tick();
      n_checks++;
      if (syn_out3 !== 6'b000100 || bin_out3 !== 6'd0) begin
         n_errors++;
         $display("FAIL s3_edge3: syn=%b bin=%0d, need syn=000100 bin=0", syn_out3, bin_out3);
      end
      tick();
      n_checks++;
      if (bin_out3 !== 6'd7 || advance3 !== 6'd7 || changed3 !== 1'b1) begin
         n_errors++;
         $display("FAIL s3_edge4: bin=%0d adv=%0d chg=%0b, need 7 7 1", bin_out3, advance3, changed3);
      end
   endtask

   initial begin
      test_reset();
      test_steady_count();
      test_jump();
      test_error();
      test_async_reset();
      test_stages3();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
